rcv_byte_ctrl: RTL and testbench
================================

# rcv_byte_ctrl

Receive-side controller that sits around a `flex_stp_sr` instance configured for 9 bits, LSB-first. It watches the serial line for a start bit and times the bit centres, pulsing `shift_strobe` into the shift register's `shift_enable`. Once the stop bit has been shifted in, it reads back the register's parallel word, checks the stop bit, and loads the data byte into a host-facing buffer with ready, overrun and framing flags. It owns the timing, the FSM and the output buffer; the shift register remains a separate instance.

## Interface
- CLKS_PER_BIT, 10, clocks per serial bit; even, ≥ 4.
- DATA_BITS, 8, data bits per frame; the paired shift register is DATA_BITS+1 wide.
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  reset, asynchronous and active-low.
- serial_in  input  1  serial line, already synchronized to clk; idle high.
- sr_data  input  DATA_BITS+1  parallel output of the shift register; [DATA_BITS] is the stop bit, [DATA_BITS-1:0] is the data.
- data_read  input  1  one-cycle host pulse: buffer consumed.
- shift_strobe  output  1  one-cycle shift enable to the shift register.
- rx_data  output  DATA_BITS  received byte buffer.
- data_ready  output  1  buffer holds an unread byte.
- overrun_error  output  1  a byte was loaded while the previous byte was unread.
- framing_error  output  1  the last frame had stop bit = 0.

## Operation
- Registers:
  - `prev_ser` (reset 1).
  - Cycle counter `cnt` (0..CLKS_PER_BIT-1).
  - Bit index `bidx` (0..DATA_BITS+1; 0 is the start bit).
  - FSM state.
- HALF = CLKS_PER_BIT/2.
- Falling edge is `prev_ser`=1 and `serial_in`=0. `prev_ser` follows `serial_in` every cycle.
- FSM state IDLE:
  - On a falling edge: go to RECV, load `cnt`←0 and `bidx`←0, clear `framing_error`.
  - Otherwise stay in IDLE.
- FSM state RECV:
  - Each cycle, `cnt` increments. At CLKS_PER_BIT-1, `cnt` wraps to 0 and `bidx` increments.
  - Start-bit check: if `bidx`=0, `cnt`=HALF and `serial_in`=1, go to IDLE. This is a false start: no strobe, no flag change.
  - `shift_strobe` = (state==RECV) and `cnt`=HALF and `bidx`≥1. It is combinational from registered state, so it is glitch-free with respect to `serial_in`.
  - At the strobe with `bidx`=DATA_BITS+1 (the stop bit), the next state is CHECK.
- FSM state CHECK (exactly 1 cycle, then IDLE). `sr_data` now holds the full frame.
  - If `sr_data[DATA_BITS]`=1:
    - `rx_data`←`sr_data[DATA_BITS-1:0]`.
    - `data_ready`←1.
    - `overrun_error`←1 if `data_ready`=1 and `data_read`=0 this cycle; otherwise `overrun_error` is unchanged.
  - If `sr_data[DATA_BITS]`=0: `framing_error`←1; `rx_data`, `data_ready` and `overrun_error` are unchanged.
- `data_read`, outside a CHECK load cycle, clears `data_ready` and `overrun_error` on the next edge.
- Simultaneous `data_read` and load in CHECK:
  - The load wins: `data_ready` stays 1 and `rx_data` takes the new byte.
  - No overrun is raised.
  - A pre-existing `overrun_error` is cleared.
- Falling edges seen during RECV or CHECK are ignored. A new frame is recognised only from IDLE; the line is high at the stop-bit centre, so back-to-back frames are captured.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE, `cnt`=0, `bidx`=0, `prev_ser`=1.
  - `rx_data`=all ones, `data_ready`=0, `overrun_error`=0, `framing_error`=0, `shift_strobe`=0.
  - The partial frame is discarded.

## Timing
- Edge numbering: let E0 be the clock edge that detects the falling edge.
- Bit k (k ≥ 1) strobe is high in the cycle between edges E0+k·CLKS_PER_BIT+HALF and the edge after it. Defaults: k=1 at E0+15, stop at E0+95.
- The shift register shifts on the following edge. CHECK is the cycle after edge E0+(DATA_BITS+1)·CLKS_PER_BIT+HALF+1.
- Outputs update at edge E0+(DATA_BITS+1)·CLKS_PER_BIT+HALF+2, which is E0+97 for the defaults.
- Exactly DATA_BITS+1 strobes per accepted frame; 0 for a false start.
- `data_ready` clear latency after `data_read`: 1 edge.
- The block is back in IDLE one cycle after CHECK, so it can detect a new start the cycle after that.

## Test plan
- Reset mid-RECV (after 40 cycles of a frame): all outputs return to their reset values immediately; `rx_data`=0xFF; no strobe follows; the next full frame is received correctly.
- Frame 0xA5, LSB first, stop=1 (defaults, with a paired shift register):
  - 9 strobes at E0+15, +25, …, +95.
  - `rx_data`=0xA5 and `data_ready`=1 after E0+97.
  - Both errors stay 0.
- Frame with stop bit 0, data 0x3C:
  - `framing_error`=1 after E0+97.
  - `data_ready` and `rx_data` unchanged.
  - `framing_error` clears at the next start edge.
- Two good frames (0x11 then 0x22) with no `data_read`: after the second frame, `rx_data`=0x22, `data_ready`=1, `overrun_error`=1. A subsequent `data_read` pulse clears both flags one edge later.
- Glitch start: `serial_in` low for 3 cycles, then high. There is no strobe, the FSM returns to IDLE at the start-bit centre, and no flag changes.
- `data_read` pulsed exactly in the CHECK cycle of a good 0x77 frame while an older byte is unread: `data_ready`=1, `rx_data`=0x77, `overrun_error`=0.

Source files
------------

// File: rtl/rcv_byte_ctrl.sv
// Serial receive controller: start detection, bit-centre strobes for an
// external LSB-first shift register, and a host byte buffer with error flags.
module rcv_byte_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS:0]   sr_data,
    input  logic                 data_read,
    output logic                 shift_strobe,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W = $clog2(DATA_BITS + 2);

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BIDX_W-1:0] BIDX_STOP = BIDX_W'(DATA_BITS + 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIDX_W-1:0]     bidx_q, bidx_d;
    logic                  prev_ser_q;
    logic [DATA_BITS-1:0]  rx_q, rx_d;
    logic                  rdy_q, rdy_d;
    logic                  ovr_q, ovr_d;
    logic                  fe_q, fe_d;
    logic                  fall;
    logic                  strobe;

    assign fall   = prev_ser_q & ~serial_in;
    assign strobe = (state_q == RECV) && (cnt_q == CNT_HALF) && (bidx_q != '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bidx_q     <= '0;
            prev_ser_q <= 1'b1;
            rx_q       <= '1;
            rdy_q      <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bidx_q     <= bidx_d;
            prev_ser_q <= serial_in;
            rx_q       <= rx_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        rx_d    = rx_q;
        rdy_d   = rdy_q;
        ovr_d   = ovr_q;
        fe_d    = fe_q;

        if (data_read) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    bidx_d  = '0;
                    fe_d    = 1'b0;
                end
            end
            RECV: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    bidx_d = bidx_q + BIDX_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                // Line high at the start-bit centre means the edge was noise.
                if (bidx_q == '0 && cnt_q == CNT_HALF && serial_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    bidx_d  = '0;
                end else if (strobe && bidx_q == BIDX_STOP) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    bidx_d  = '0;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (sr_data[DATA_BITS]) begin
                    rx_d  = sr_data[DATA_BITS-1:0];
                    rdy_d = 1'b1;
                    ovr_d = !data_read && (ovr_q || rdy_q);
                end else begin
                    fe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_strobe  = strobe;
    assign rx_data       = rx_q;
    assign data_ready    = rdy_q;
    assign overrun_error = ovr_q;
    assign framing_error = fe_q;

endmodule

// File: tb/tb_rcv_byte_ctrl.sv
// Scoreboard bench for rcv_byte_ctrl with a behavioural paired shift register
// and a frame-level reference model of the host buffer.
module tb_rcv_byte_ctrl;

    localparam int CPB = 10;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          serial_in = 1'b1;
    logic          data_read = 1'b0;
    logic [DB:0]   sr_data = '0;
    logic          shift_strobe;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int        t;
        string     nm;
        logic [7:0] rx;
        logic      rdy;
        logic      ovr;
        logic      fe;
    } exp_t;

    exp_t eq[$];
    int   sq[$];
    exp_t mon_e;

    logic [7:0] m_rx  = 8'hFF;
    logic       m_rdy = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LSB-first shift register paired with the controller
    always @(posedge clk) if (shift_strobe) sr_data <= {serial_in, sr_data[DB:1]};

    rcv_byte_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .sr_data       (sr_data),
        .data_read     (data_read),
        .shift_strobe  (shift_strobe),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    task automatic push_exp(input int t, input string nm);
        exp_t e;
        e.t   = t;
        e.nm  = nm;
        e.rx  = m_rx;
        e.rdy = m_rdy;
        e.ovr = m_ovr;
        e.fe  = m_fe;
        eq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: strobe timing and output snapshots at their due cycles
    always @(negedge clk) begin
        if (sq.size() > 0 && sq[0] == cyc) begin
            void'(sq.pop_front());
            chk("strobe", {7'd0, shift_strobe}, 8'd1);
        end else if (shift_strobe) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe at cycle %0d: got 1 expected 0", cyc);
        end
        while (eq.size() > 0 && eq[0].t <= cyc) begin
            mon_e = eq.pop_front();
            if (mon_e.t != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s late: got cycle %0d expected %0d", mon_e.nm, cyc, mon_e.t);
            end
            chk({mon_e.nm, ".rx_data"}, rx_data, mon_e.rx);
            chk({mon_e.nm, ".data_ready"}, {7'd0, data_ready}, {7'd0, mon_e.rdy});
            chk({mon_e.nm, ".overrun"}, {7'd0, overrun_error}, {7'd0, mon_e.ovr});
            chk({mon_e.nm, ".framing"}, {7'd0, framing_error}, {7'd0, mon_e.fe});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drives one frame; i counts cycles after edge E0-1. abort_at < 0 never aborts.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd,
                              input int abort_at);
        int e0;
        @(posedge clk); #1;
        e0 = cyc + 1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i == abort_at) begin
                n_rst = 1'b0;
                serial_in = 1'b1;
                m_rx = 8'hFF;
                m_rdy = 1'b0;
                m_ovr = 1'b0;
                m_fe = 1'b0;
                sq.delete();
                push_exp(cyc, "reset_mid");
                return;
            end
            if (i < 10) serial_in = 1'b0;
            else if (i < 90) serial_in = d[i/10-1];
            else if (i < 98) serial_in = stop;
            else serial_in = 1'b1;
            if (i == 0) begin
                m_fe = 1'b0;
                push_exp(e0, "start");
                for (int k = 1; k <= DB + 1; k++) sq.push_back(e0 + k*CPB + CPB/2);
            end
            if (i == 97) begin
                data_read = rd;
                if (stop) begin
                    m_ovr = rd ? 1'b0 : (m_ovr | m_rdy);
                    m_rdy = 1'b1;
                    m_rx  = d;
                end else begin
                    m_fe = 1'b1;
                    if (rd) begin
                        m_rdy = 1'b0;
                        m_ovr = 1'b0;
                    end
                end
                push_exp(e0 + 97, "frame");
            end
            if (i == 98) data_read = 1'b0;
        end
    endtask

    task automatic do_read();
        @(posedge clk); #1;
        data_read = 1'b1;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        push_exp(cyc + 1, "read");
        @(posedge clk); #1;
        data_read = 1'b0;
    endtask

    task automatic glitch();
        int e0;
        @(posedge clk); #1;
        serial_in = 1'b0;
        e0 = cyc + 1;
        m_fe = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        push_exp(e0 + 10, "glitch");
        idle(20);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       st;
        logic       rd;
        repeat (3) @(posedge clk);
        #1 push_exp(cyc, "reset");
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        do_read();
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        do_read();
        glitch();
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'h66, 1'b1, 1'b0, -1);
        send_frame(8'h77, 1'b1, 1'b1, -1);

        send_frame(8'hC3, 1'b1, 1'b0, 40);
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0);
            send_frame(d, st, rd, -1);
            if ($urandom_range(0, 1) == 1) do_read();
        end

        idle(20);
        checks++;
        if (eq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d/%0d outstanding expected 0/0", eq.size(), sq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
